// File: rtl/mux_pkg.sv
// mux_pkg: shared defaults, mode encodings and width helper for the N:1 pipelined mux
package mux_pkg;
   localparam int MUX_N_DEF = 8;
   localparam int MUX_W_DEF = 8;
   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN = 1'b1;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
      return r;
   endfunction
endpackage

// File: rtl/mux_nx1_pipe_if.sv
// mux_nx1_pipe_if: channel inputs, controls and registered output of the N:1 pipelined mux
interface mux_nx1_pipe_if #(
   parameter int N = mux_pkg::MUX_N_DEF,
   parameter int W = mux_pkg::MUX_W_DEF
);
   localparam int SW = mux_pkg::clog2(N);
   logic [N*W-1:0] i_data;
   logic [N-1:0] i_valid;
   logic [SW-1:0] sel;
   logic mode;
   logic en;
   logic y_ready;
   logic [W-1:0] y;
   logic y_valid;
   logic [SW-1:0] y_ch;
   modport master(output i_data, i_valid, sel, mode, en, y_ready, input y, y_valid, y_ch);
   modport slave(input i_data, i_valid, sel, mode, en, y_ready, output y, y_valid, y_ch);
endinterface

// File: rtl/mux_tree_nx1.sv
// mux_tree_nx1: combinational N:1 selector built as log2(N) levels of 2:1 stages, sel bit 0 at the leaves
module mux_tree_nx1 import mux_pkg::*; #(
   parameter int N = MUX_N_DEF,
   parameter int W = MUX_W_DEF
) (
   input  logic [N*W-1:0]        data_i,
   input  logic [clog2(N)-1:0]   sel_i,
   output logic [W-1:0]          y_o
);
   localparam int SW = clog2(N);
   logic [W-1:0] node [N];
   // level l folds node pairs in place; node j only reads 2j and 2j+1, so no overwrite hazard
   always_comb begin
      for (int k = 0; k < N; k++) node[k] = data_i[k*W +: W];
      for (int l = 0; l < SW; l++)
         for (int j = 0; j < (N >> (l + 1)); j++)
            node[j] = sel_i[l] ? node[2*j+1] : node[2*j];
      y_o = node[0];
   end
endmodule

// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: registered N:1 channel mux with ready/valid output, manual select or round-robin scan
// Round-robin scan and its pointer exist only when MUX_SCAN_EN is defined; otherwise mode is ignored.
module mux_nx1_pipe import mux_pkg::*; #(
   parameter int N = MUX_N_DEF,
   parameter int W = MUX_W_DEF
) (
   input logic clk,
   input logic rst_n,
   mux_nx1_pipe_if.slave bus
);
   localparam int SW = clog2(N);
   logic [W-1:0] y_q, y_d, mux_y;
   logic [SW-1:0] ch_q, ch_d, pick;
   logic v_q, v_d, ld, ld_v, upd;
   assign ld = bus.en & (~v_q | bus.y_ready);
   mux_tree_nx1 #(.N(N), .W(W)) u_tree (.data_i(bus.i_data), .sel_i(pick), .y_o(mux_y));
`ifdef MUX_SCAN_EN
   logic [SW-1:0] ptr_q, ptr_d, hit_ch;
   logic hit, scan;
   // walk from the far end back to ptr so the channel nearest ptr wins
   always_comb begin
      hit = 1'b0;
      hit_ch = ptr_q;
      for (int k = N - 1; k >= 0; k--) begin
         hit = hit | bus.i_valid[ptr_q + SW'(k)];
         hit_ch = bus.i_valid[ptr_q + SW'(k)] ? ptr_q + SW'(k) : hit_ch;
      end
   end
   assign scan = bus.mode == MODE_SCAN;
   assign pick = scan ? hit_ch : bus.sel;
   assign ld_v = scan ? hit : bus.i_valid[bus.sel];
   assign upd = ld & (~scan | hit);
   assign ptr_d = (upd & scan) ? hit_ch + SW'(1) : ptr_q;
   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= '0;
      else ptr_q <= ptr_d;
   end
`else
   logic unused_mode;
   assign unused_mode = bus.mode;
   assign pick = bus.sel;
   assign ld_v = bus.i_valid[bus.sel];
   assign upd = ld;
`endif
   always_comb begin
      y_d = upd ? mux_y : y_q;
      ch_d = upd ? pick : ch_q;
      v_d = ld ? ld_v : v_q & ~bus.y_ready;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_q <= '0;
         ch_q <= '0;
         v_q <= 1'b0;
      end else begin
         y_q <= y_d;
         ch_q <= ch_d;
         v_q <= v_d;
      end
   end
   assign bus.y = y_q;
   assign bus.y_ch = ch_q;
   assign bus.y_valid = v_q;
endmodule

// File: doc/mux_nx1_pipe.md
MUX_NX1_PIPE -- requirements
Module: mux_nx1_pipe

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning channel count (power of 2, 2..64).
REQ-002 The block SHALL have parameter W, default 8, meaning data width per channel (1..64).
REQ-003 The block SHALL derive SW = clog2(N), meaning select and channel-index width.
REQ-004 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous and active-low.
REQ-006 i_data  in  N*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
REQ-007 i_valid  in  N  per-channel valid; bit k qualifies channel k.
REQ-008 sel  in  SW  channel index used in manual mode.
REQ-009 mode  in  1  0 = manual select, 1 = round-robin scan.
REQ-010 en  in  1  load enable.
REQ-011 y_ready  in  1  downstream accepts y this cycle.
REQ-012 y  out  W  registered selected data.
REQ-013 y_valid  out  1  y holds a valid word.
REQ-014 y_ch  out  SW  index of the channel that produced y.

Function
REQ-015 Load condition SHALL be ld = en & (~y_valid | y_ready); latency from input to y SHALL be exactly 1 cycle.
REQ-016 Manual mode, ld=1: y <= channel sel data, y_ch <= sel, y_valid <= i_valid[sel].
REQ-017 Scan mode, ld=1: pick the first channel c with i_valid[c]=1, searching ptr, ptr+1, ... wrapping N-1 -> 0; load y, y_ch <= c, y_valid <= 1, ptr <= (c+1) mod N.
REQ-018 Scan mode, ld=1, no i_valid bit set: y_valid <= 0; y, y_ch and ptr SHALL hold.
REQ-019 Stall (y_valid=1, y_ready=0): y, y_ch, y_valid and ptr SHALL hold regardless of en, mode, sel or inputs.
REQ-020 en=0 with y_valid=1 and y_ready=1: y_valid <= 0; y, y_ch and ptr SHALL hold.
REQ-021 en=0 otherwise: all state SHALL hold.
REQ-022 Mode change SHALL take effect on the next load; ptr SHALL NOT be cleared by a mode change and SHALL NOT advance in manual mode.
REQ-023 The output register SHALL accept a new word in the same cycle as the previous one is consumed (y_valid=1, y_ready=1, en=1), giving full throughput with no bubble.

Reset
REQ-024 While rst_n=0 at a clock edge: y=0, y_valid=0, y_ch=0 and ptr=0; reset SHALL override en, y_ready and mode.
REQ-025 Reset asserted mid-stall SHALL discard the held word; the first load after release SHALL search from channel 0.

Configuration
REQ-026 Macro MUX_SCAN_EN defined: scan mode, ptr and the round-robin search logic SHALL be compiled in.
REQ-027 Macro MUX_SCAN_EN undefined: the mode port SHALL remain present but be ignored, the block SHALL behave as manual mode only, and no ptr register SHALL exist.

Structure
REQ-028 Package mux_pkg SHALL hold MUX_N_DEF=8, MUX_W_DEF=8, MODE_MANUAL=1'b0, MODE_SCAN=1'b1 and a constant clog2 function.
REQ-029 Combinational selection SHALL be a sub-module mux_tree_nx1 (parameters N and W), built as a log2(N)-level tree of 2:1 stages, with sel bit 0 driving the leaf level.

Verification (N=8, W=8)
REQ-030 Reset and manual select: rst_n=0 for 2 cycles, then manual mode, sel=5, i_data ch5=8'hA5, i_valid=8'hFF, en=1, y_ready=1 -> after reset, outputs are 0; one cycle later y=8'hA5, y_ch=5, y_valid=1.
REQ-031 Scan wrap: scan mode, i_valid=8'b1000_0011, ptr=0, y_ready=1 -> y_ch sequence 0, 1, 7, 0, 1.
REQ-032 Stall: y_valid=1 with y_ch=3, y_ready=0 for 4 cycles while sel and i_data change -> y, y_ch and ptr are unchanged; on y_ready=1 the next word loads in the same cycle.
REQ-033 Empty scan: scan mode, i_valid=0, en=1 -> y_valid=0 next cycle with ptr held; then i_valid=8'h10 -> y_ch=4, y_valid=1.
REQ-034 Reset mid-stall: word held, rst_n=0 for 1 cycle -> y_valid=0, y=0; next scan with i_valid=8'hFF -> y_ch=0.
REQ-035 Build without MUX_SCAN_EN: mode=1, sel=2 -> y_ch=2 each load, identical to manual mode.
